// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: valid/ready sequencer around the Caesar encrypt datapath.
// Each character is shifted by a key entry. The key buffer is read cyclically,
// and only digits and letters consume an entry. The ciphertext is returned on a
// registered output stage that carries the message framing flag.
module cipher_stream_ctrl #(
  parameter int KEY_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_wr,
  input  logic [7:0]                   key_data,
  input  logic                         key_clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_char,
  output logic                         out_last,
  output logic                         busy,
  output logic [$clog2(KEY_DEPTH):0]   key_len,
  output logic [CNT_W-1:0]             char_count
);

  localparam int PW = $clog2(KEY_DEPTH);
  localparam int KW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  // True for ASCII digits and upper/lower-case letters.
  function automatic logic is_alnum(input logic [7:0] c);
    is_alnum = ((c >= 8'd48) && (c <= 8'd57)) ||
               ((c >= 8'd65) && (c <= 8'd90)) ||
               ((c >= 8'd97) && (c <= 8'd122));
  endfunction

  // Combinational Caesar datapath: each class wraps within its own range.
  function automatic logic [7:0] encrypt(input logic [7:0] c, input logic [7:0] sh);
    logic [7:0] sum;
    sum = 8'd0;
    if ((c >= 8'd48) && (c <= 8'd57)) begin
      sum = (c - 8'd48) + (sh % 8'd10);
      if (sum >= 8'd10) sum = sum - 8'd10;
      else              sum = sum;
      encrypt = sum + 8'd48;
    end else if ((c >= 8'd65) && (c <= 8'd90)) begin
      sum = (c - 8'd65) + (sh % 8'd26);
      if (sum >= 8'd26) sum = sum - 8'd26;
      else              sum = sum;
      encrypt = sum + 8'd65;
    end else if ((c >= 8'd97) && (c <= 8'd122)) begin
      sum = (c - 8'd97) + (sh % 8'd26);
      if (sum >= 8'd26) sum = sum - 8'd26;
      else              sum = sum;
      encrypt = sum + 8'd97;
    end else begin
      encrypt = c;
    end
  endfunction

  state_t            state_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [7:0]        out_char_r;
  logic              out_last_r;
  logic [KW-1:0]     key_len_r;
  logic [PW-1:0]     kptr_r;
  logic [CNT_W-1:0]  char_count_r;
  logic [7:0]        key_mem_r [KEY_DEPTH];

  logic              in_ready_s;
  logic              accept_s;
  logic              key_idle_s;
  logic              key_full_s;
  logic              alnum_s;
  logic [7:0]        shift_s;
  logic [PW-1:0]     kptr_inc_s;

  // Handshake, shift selection and next key pointer.
  always_comb begin
    in_ready_s = (state_r != FLUSH) && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
    key_idle_s = (state_r == IDLE);
    key_full_s = (key_len_r == KW'(KEY_DEPTH));
    alnum_s    = is_alnum(in_char);
    if (key_len_r != {KW{1'b0}}) shift_s = key_mem_r[kptr_r];
    else                         shift_s = 8'd0;
    if (({1'b0, kptr_r} + {{PW{1'b0}}, 1'b1}) >= key_len_r) kptr_inc_s = {PW{1'b0}};
    else                                                    kptr_inc_s = kptr_r + {{(PW-1){1'b0}}, 1'b1};
  end

  // Message FSM with registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= in_last ? FLUSH : RUN;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (accept_s && in_last) state_r <= FLUSH;
        end
        FLUSH: begin
          if (out_valid_r && out_ready && out_last_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on accept, drain on out_ready otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_char_r  <= 8'd0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_char_r  <= encrypt(in_char, shift_s);
      out_last_r  <= in_last;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Key pointer: steps on alphanumerics, restarts at message end or key clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kptr_r <= {PW{1'b0}};
    end else if (key_idle_s && key_clr) begin
      kptr_r <= {PW{1'b0}};
    end else if (accept_s && in_last) begin
      kptr_r <= {PW{1'b0}};
    end else if (accept_s && alnum_s && (key_len_r != {KW{1'b0}})) begin
      kptr_r <= kptr_inc_s;
    end
  end

  // Key length: programmable only while idle; clear beats write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_len_r <= {KW{1'b0}};
    end else if (key_idle_s && key_clr) begin
      key_len_r <= {KW{1'b0}};
    end else if (key_idle_s && key_wr && !key_full_s) begin
      key_len_r <= key_len_r + {{PW{1'b0}}, 1'b1};
    end
  end

  // Key storage: contents need no reset because key_len gates every read.
  always_ff @(posedge clk) begin
    if (key_idle_s && !key_clr && key_wr && !key_full_s) begin
      key_mem_r[key_len_r[PW-1:0]] <= key_data;
    end
  end

  // Character counter: restarts per message and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && key_idle_s) begin
      char_count_r <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (accept_s && (char_count_r != {CNT_W{1'b1}})) begin
      char_count_r <= char_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_char   = out_char_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;
  assign key_len    = key_len_r;
  assign char_count = char_count_r;

endmodule

// File: doc/cipher_stream_ctrl.md
# cipher_stream_ctrl

Sequencing controller around the team's combinational Caesar `encrypt` datapath: accepts an ASCII character stream over a valid/ready handshake and applies a per-character shift drawn cyclically from a programmable key buffer (Vigenère-style). Results are returned on a registered valid/ready output with message framing. It sits between the character source (keypad/UART front end) and the alphanumeric display driver, and it owns the only `encrypt` instance in the path.

## Interface
- `KEY_DEPTH`, default 8: key buffer entries; a power of two, at least 2.
- `CNT_W`, default 16: width of `char_count`.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset. One clock, no other clock domains.
- `key_wr`  in  1: append `key_data` to the key buffer.
- `key_data`  in  8: shift value for that key entry.
- `key_clr`  in  1: empty the key buffer (`key_len` ← 0).
- `in_valid` / `in_ready`  in / out  1: input handshake.
- `in_char`  in  8: plaintext ASCII character.
- `in_last`  in  1: marks the final character of a message.
- `out_valid` / `out_ready`  out / in  1: output handshake.
- `out_char`  out  8: ciphertext character.
- `out_last`  out  1: copy of `in_last` for this character.
- `busy`  out  1: high whenever the state is not IDLE.
- `key_len`  out  $clog2(KEY_DEPTH)+1: number of valid key entries.
- `char_count`  out  CNT_W: characters accepted in the current or most recent message; saturates at all-ones.

## Operation
- FSM states are IDLE, RUN and FLUSH.
  - IDLE → RUN when an input is accepted with `in_last`=0.
  - IDLE → FLUSH when an input is accepted with `in_last`=1.
  - RUN → FLUSH when an input is accepted with `in_last`=1.
  - FLUSH → IDLE when the output handshake completes with `out_last`=1.
- Input accept condition: `in_valid && in_ready`.
- `in_ready` = (state≠FLUSH) && (!`out_valid` || `out_ready`).
- Shift for each character:
  - `key[kptr]` when `key_len`>0.
  - 0 when `key_len`=0, so every character passes through unchanged.
- `encrypt` semantics:
  - Digits 48–57 are shifted by shift%10 and wrap within 48–57.
  - `A`–`Z` and `a`–`z` are shifted by shift%26 and wrap within their own case.
  - All other codes pass through unchanged.
- Key pointer `kptr` advances only when the accepted character is a digit or a letter.
  - It wraps to 0 when it reaches `key_len`.
  - Non-alphanumeric characters do not consume a key entry.
- `kptr` ← 0 on reset, on any accept with `in_last`=1, and on `key_clr`.
- `char_count`:
  - Loads 1 on an accept in IDLE.
  - Increments on each accept in RUN, holding at all-ones.
  - Holds its value in FLUSH and IDLE until the next message starts.
- Key programming:
  - Honoured only in IDLE.
  - `key_wr` or `key_clr` outside IDLE is ignored.
  - `key_wr` when `key_len`=KEY_DEPTH is ignored.
  - If `key_clr` and `key_wr` are asserted in the same cycle, the clear wins and the write is dropped.
- Key entries are stored as written (full 8 bits). The modulo reduction is done by the datapath.

## Timing
- Reset values:
  - `out_valid`=0, `out_char`=0, `out_last`=0.
  - `busy`=0, `key_len`=0, `char_count`=0.
  - State IDLE, `kptr`=0.
  - `in_ready`=1, since it is derived from the above.
  - Key storage contents are don't-care.
- Latency: a character accepted at edge N is presented with `out_valid`=1 after edge N. One-cycle latency, registered output.
- Output register behaviour:
  - Updates on every accept.
  - `out_valid` clears on `out_ready` when there is no simultaneous accept.
  - A simultaneous drain and accept replaces the contents, giving full throughput of one character per cycle.
- While `out_valid`=1 and `out_ready`=0, `out_char` and `out_last` hold stable.
- FLUSH inserts no extra cycle when `out_ready` is high. A new message is accepted on the cycle after the last output handshake.
- `busy` and `char_count` are registered and update on the accept edge.
- `key_len` updates on the edge after `key_wr` or `key_clr`.
- Reset asserted mid-message:
  - Clears state, output and counters immediately (asynchronously).
  - Discards any pending output.
  - Also clears the key, so the key must be reprogrammed after reset.

## Test plan
- Key [3]; send "Az9" with the last flag on "9", `out_ready`=1 → outputs "D","c","2" on consecutive cycles. `out_last`=1 only on "2". `char_count`=3; `busy` back to 0 one cycle after the final output handshake.
- Key [1,2]; send "ab!c" → outputs "b","d","!","d". The "!" does not advance the pointer. A following message "a" → "b", confirming the pointer restarts at 0.
- Key empty; send "Hi 5" → outputs "Hi 5" unchanged. Key [255] on "A" → "V" (255%26=21); on "0" → "5" (255%10=5).
- Backpressure: hold `out_ready`=0 for 5 cycles mid-stream → `in_ready`=0 and `out_char` stable. Release it → no character is lost or duplicated, and throughput returns to one per cycle.
- Write 9 keys with KEY_DEPTH=8 → `key_len`=8 and the 9th is ignored. `key_wr` during RUN is ignored. `key_clr` together with `key_wr` in IDLE → `key_len`=0.
- Assert `rst_n`=0 while in RUN with `out_valid`=1 → `out_valid`, `busy`, `key_len` and `char_count` are all 0 with no clock edge required. After release, `in_ready`=1.
